// File: rtl/user_obi_arb_if.sv
// OBI request/response bundle with NumPorts request lanes sharing one response data/error lane.
// The master modport issues requests; the slave modport grants them and returns responses.
interface user_obi_arb_if #(
    parameter int NumPorts  = 1,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic [NumPorts-1:0]                  req;
    logic [NumPorts-1:0]                  gnt;
    logic [NumPorts-1:0][AddrWidth-1:0]   addr;
    logic [NumPorts-1:0]                  we;
    logic [NumPorts-1:0][DataWidth/8-1:0] be;
    logic [NumPorts-1:0][DataWidth-1:0]   wdata;
    logic [NumPorts-1:0]                  rvalid;
    logic [DataWidth-1:0]                 rdata;
    logic                                 err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/user_obi_arb.sv
// Round-robin OBI arbiter sharing the user-domain BBS32 subordinate between NumMgr managers.
// An ownership FIFO records which manager issued each outstanding transaction so responses route back.
module user_obi_arb #(
    parameter int NumMgr    = 2,
    parameter int MaxTrans  = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    user_obi_arb_if.slave  mgr_bus,
    user_obi_arb_if.master sbr_bus,
    output logic           proto_err_o
);
    localparam int SelW = $clog2(NumMgr);
    localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int CntW = $clog2(MaxTrans + 1);
    localparam logic [SelW-1:0] LastMgr   = SelW'(NumMgr - 1);
    localparam logic [PtrW-1:0] LastSlot  = PtrW'(MaxTrans - 1);
    localparam logic [CntW-1:0] FullCount = CntW'(MaxTrans);

    logic [SelW-1:0] rr_q;
    logic [SelW-1:0] sel_q;
    logic            lock_q;
    logic [SelW-1:0] scan_sel;
    logic [SelW-1:0] sel;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [SelW-1:0] owner_q [MaxTrans];
    logic            proto_err_q;
    logic            any_req;
    logic            fifo_full;
    logic            fifo_empty;
    logic            sbr_req;
    logic            handshake;
    logic            pop;
    logic            stray;

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin : scan
        int  idx;
        logic found;
        scan_sel = rr_q;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NumMgr; k++) begin
            idx = (int'(rr_q) + k) % NumMgr;
            if (!found && mgr_bus.req[idx]) begin
                found    = 1'b1;
                scan_sel = SelW'(idx);
            end
        end
    end

    assign sel        = lock_q ? sel_q : scan_sel;
    assign any_req    = |mgr_bus.req;
    assign fifo_full  = (count_q == FullCount);
    assign fifo_empty = (count_q == '0);
    assign sbr_req    = any_req & ~fifo_full;
    assign handshake  = sbr_req & sbr_bus.gnt[0];
    assign pop        = sbr_bus.rvalid[0] & ~fifo_empty;
    assign stray      = sbr_bus.rvalid[0] & fifo_empty;

    assign sbr_bus.req[0]   = sbr_req;
    assign sbr_bus.addr[0]  = mgr_bus.addr[sel];
    assign sbr_bus.we[0]    = mgr_bus.we[sel];
    assign sbr_bus.be[0]    = mgr_bus.be[sel];
    assign sbr_bus.wdata[0] = mgr_bus.wdata[sel];

    assign mgr_bus.rdata = sbr_bus.rdata;
    assign mgr_bus.err   = sbr_bus.err;
    assign proto_err_o   = proto_err_q;

    always_comb begin
        mgr_bus.gnt    = '0;
        mgr_bus.rvalid = '0;
        if (handshake) begin
            mgr_bus.gnt[sel] = 1'b1;
        end
        if (pop) begin
            mgr_bus.rvalid[owner_q[rd_ptr_q]] = 1'b1;
        end
    end

    // A stalled request keeps its selection so the subordinate-side fields stay stable until granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            sel_q       <= '0;
            lock_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (handshake) begin
                rr_q     <= (sel == LastMgr) ? '0 : sel + 1'b1;
                lock_q   <= 1'b0;
                wr_ptr_q <= (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + 1'b1;
            end else if (sbr_req) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({handshake, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (stray) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            owner_q[wr_ptr_q] <= sel;
        end
    end
endmodule
